mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter for a single mfc-handshaked memory port.
// Define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles without mfc.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        ifReq,
   input  logic [31:0] ifAddr,
   input  logic        dReq,
   input  logic        dRW,
   input  logic [31:0] dAddr,
   input  logic [31:0] dWdata,
   input  logic        mfc,
   input  logic [31:0] memRdata,
   output logic        memEn,
   output logic        memRW,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   output logic        ifGnt,
   output logic        dGnt,
   output logic        ifDone,
   output logic        dDone,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic        own_q, own_d;      // 1 = data owns the port
   logic        last_q, last_d;    // 1 = data was granted last
   logic [31:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        pick_data;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   always_comb begin
      cnt_d = '0;
      if (state_q == WAIT && !mfc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end
`endif

   // Tie goes to whichever requester was not served last.
   assign pick_data = dReq && (!ifReq || !last_q);

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      addr_d  = addr_q;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef MEM_TIMEOUT_EN
            err_d = 1'b0;
`endif
            if (ifReq || dReq) begin
               own_d   = pick_data;
               last_d  = pick_data;
               addr_d  = pick_data ? dAddr : ifAddr;
               rw_d    = pick_data && dRW;
               wdata_d = pick_data ? dWdata : '0;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (mfc) begin
               if (!rw_q) begin
                  rdata_d = memRdata;
               end
               state_d = DONE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         own_q   <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = (state_q == DONE) && err_q;
`else
   assign err = 1'b0;
`endif

   assign busy     = (state_q != IDLE);
   assign memEn    = (state_q == WAIT);
   assign memAddr  = busy ? addr_q : '0;
   assign memRW    = busy && rw_q;
   assign memWdata = busy ? wdata_q : '0;
   assign ifGnt    = busy && !own_q;
   assign dGnt     = busy && own_q;
   assign ifDone   = (state_q == DONE) && !own_q;
   assign dDone    = (state_q == DONE) && own_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch/data transactions, arbitration,
// mid-transaction reset and WAIT timeout (both MEM_TIMEOUT_EN builds).
module tb_mem_arbiter;

   logic        clk;
   logic        clr;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic        dReq;
   logic        dRW;
   logic [31:0] dAddr;
   logic [31:0] dWdata;
   logic        mfc;
   logic [31:0] memRdata;
   logic        memEn;
   logic        memRW;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic        ifGnt;
   logic        dGnt;
   logic        ifDone;
   logic        dDone;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   int passed = 0;
   int total  = 0;
   logic [31:0] exp_rdata;

   mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .clr(clr), .ifReq(ifReq), .ifAddr(ifAddr), .dReq(dReq),
      .dRW(dRW), .dAddr(dAddr), .dWdata(dWdata), .mfc(mfc), .memRdata(memRdata),
      .memEn(memEn), .memRW(memRW), .memAddr(memAddr), .memWdata(memWdata),
      .ifGnt(ifGnt), .dGnt(dGnt), .ifDone(ifDone), .dDone(dDone),
      .rdata(rdata), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      clr = 1'b0; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dRW = 1'b0;
      dAddr = '0; dWdata = '0; mfc = 1'b0; memRdata = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({memEn, memRW, memAddr, memWdata, ifGnt, dGnt, ifDone, dDone, rdata, busy, err} !== '0)
         $display("FAIL reset_outputs: got en=%b rw=%b addr=%h wd=%h gnt=%b%b done=%b%b rdata=%h busy=%b err=%b, expected all 0",
                  memEn, memRW, memAddr, memWdata, ifGnt, dGnt, ifDone, dDone, rdata, busy, err);
      else passed++;
      clr = 1'b1;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b expected 0", busy);
      else passed++;
      exp_rdata = '0;
   endtask

   task automatic test_fetch;
      ifReq = 1'b1; ifAddr = 32'h100;
      @(negedge clk);
      total++;
      if ({ifGnt, dGnt} !== 2'b10) $display("FAIL fetch_grant: got %b expected 10", {ifGnt, dGnt});
      else passed++;
      total++;
      if ({memEn, memRW, memAddr} !== {1'b0, 1'b0, 32'h100})
         $display("FAIL fetch_issue: en=%b rw=%b addr=%h expected en=0 rw=0 addr=00000100", memEn, memRW, memAddr);
      else passed++;
      mfc = 1'b1; memRdata = 32'hE3A01005;
      @(negedge clk);
      total++;
      if ({memEn, memRW, memAddr} !== {1'b1, 1'b0, 32'h100})
         $display("FAIL fetch_wait: en=%b rw=%b addr=%h expected en=1 rw=0 addr=00000100", memEn, memRW, memAddr);
      else passed++;
      @(negedge clk);
      total++;
      if ({ifDone, dDone, memEn, err} !== 4'b1000)
         $display("FAIL fetch_done: ifDone=%b dDone=%b en=%b err=%b expected 1 0 0 0", ifDone, dDone, memEn, err);
      else passed++;
      total++;
      if (rdata !== 32'hE3A01005) $display("FAIL fetch_rdata: got %h expected e3a01005", rdata);
      else passed++;
      exp_rdata = 32'hE3A01005;
      ifReq = 1'b0; mfc = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, ifDone, ifGnt} !== 3'b000) $display("FAIL fetch_idle: busy/ifDone/ifGnt=%b expected 000", {busy, ifDone, ifGnt});
      else passed++;
   endtask

   task automatic test_mfc_ignored;
      mfc = 1'b1; memRdata = 32'h55555555;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, ifDone, dDone} !== 3'b000 || rdata !== exp_rdata)
         $display("FAIL mfc_in_idle: busy/dones=%b rdata=%h expected 000 rdata=%h", {busy, ifDone, dDone}, rdata, exp_rdata);
      else passed++;
      mfc = 1'b0;
   endtask

   task automatic test_arbitration;
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      exp_rdata = '0;
      ifAddr = 32'h200; dAddr = 32'h300; dRW = 1'b0; dWdata = 32'h0;
      memRdata = 32'hA5A50001; mfc = 1'b1;
      ifReq = 1'b1; dReq = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if ({ifGnt, dGnt} !== ((k == 1) ? 2'b01 : 2'b10))
            $display("FAIL arb_grant_%0d: got %b expected %b", k, {ifGnt, dGnt}, (k == 1) ? 2'b01 : 2'b10);
         else passed++;
         total++;
         if (memAddr !== ((k == 1) ? 32'h300 : 32'h200))
            $display("FAIL arb_addr_%0d: got %h expected %h", k, memAddr, (k == 1) ? 32'h300 : 32'h200);
         else passed++;
         repeat (2) @(negedge clk);
         total++;
         if ({ifDone, dDone} !== ((k == 1) ? 2'b01 : 2'b10))
            $display("FAIL arb_done_%0d: got %b expected %b", k, {ifDone, dDone}, (k == 1) ? 2'b01 : 2'b10);
         else passed++;
         @(negedge clk);
         total++;
         if ({busy, ifGnt, dGnt} !== 3'b000)
            $display("FAIL no_back_to_back_%0d: busy/gnt=%b expected 000", k, {busy, ifGnt, dGnt});
         else passed++;
      end
      ifReq = 1'b0; dReq = 1'b0; mfc = 1'b0;
      exp_rdata = 32'hA5A50001;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || rdata !== exp_rdata)
         $display("FAIL arb_end: busy=%b rdata=%h expected 0 %h", busy, rdata, exp_rdata);
      else passed++;
   endtask

   task automatic test_write;
      int en_cnt = 0;
      int done_cnt = 0;
      int bad_bus = 0;
      int err_cnt = 0;
      dReq = 1'b1; dRW = 1'b1; dAddr = 32'h20; dWdata = 32'hDEADBEEF;
      memRdata = 32'h12345678; mfc = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (memEn) begin
            en_cnt++;
            if ({memRW, memAddr, memWdata} !== {1'b1, 32'h20, 32'hDEADBEEF}) bad_bus++;
         end
         if (err) err_cnt++;
         if (en_cnt == 6 && memEn) mfc = 1'b1;
         if (dDone) begin
            done_cnt++;
            dReq = 1'b0; mfc = 1'b0;
         end
      end
      total++;
      if (en_cnt !== 6) $display("FAIL write_en_cycles: got %0d expected 6", en_cnt);
      else passed++;
      total++;
      if (done_cnt !== 1) $display("FAIL write_done_pulses: got %0d expected 1", done_cnt);
      else passed++;
      total++;
      if (bad_bus !== 0) $display("FAIL write_bus: %0d cycles with wrong rw/addr/wdata, expected 0", bad_bus);
      else passed++;
      total++;
      if (rdata !== exp_rdata) $display("FAIL write_rdata_held: got %h expected %h", rdata, exp_rdata);
      else passed++;
      total++;
      if (err_cnt !== 0) $display("FAIL write_err: err high %0d cycles expected 0", err_cnt);
      else passed++;
   endtask

   task automatic test_reset_mid;
      int done_cnt = 0;
      ifReq = 1'b1; ifAddr = 32'h400; dRW = 1'b0; dAddr = 32'h404; mfc = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (memEn !== 1'b1) $display("FAIL mid_pre_wait: memEn=%b expected 1", memEn);
      else passed++;
      dReq = 1'b1;
      #2 clr = 1'b0;
      #1;
      total++;
      if ({memEn, memRW, memAddr, memWdata, ifGnt, dGnt, ifDone, dDone, rdata, busy, err} !== '0)
         $display("FAIL mid_reset_outputs: en=%b addr=%h gnt=%b%b rdata=%h busy=%b expected all 0",
                  memEn, memAddr, ifGnt, dGnt, rdata, busy);
      else passed++;
      exp_rdata = '0;
      repeat (2) begin
         @(negedge clk);
         if (ifDone || dDone) done_cnt++;
      end
      total++;
      if (done_cnt !== 0) $display("FAIL mid_no_done: %0d done pulses expected 0", done_cnt);
      else passed++;
      clr = 1'b1;
      @(negedge clk);
      total++;
      if ({ifGnt, dGnt} !== 2'b10) $display("FAIL mid_rearb: got %b expected 10", {ifGnt, dGnt});
      else passed++;
      mfc = 1'b1; memRdata = 32'h0BADF00D;
      repeat (2) @(negedge clk);
      total++;
      if (ifDone !== 1'b1 || rdata !== 32'h0BADF00D)
         $display("FAIL mid_after: ifDone=%b rdata=%h expected 1 0badf00d", ifDone, rdata);
      else passed++;
      exp_rdata = 32'h0BADF00D;
      ifReq = 1'b0; dReq = 1'b0; mfc = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout;
      int en_cnt = 0;
      int done_cnt = 0;
      logic err_at = 1'b0;
      logic [31:0] rd_at = '0;
`ifdef MEM_TIMEOUT_EN
      int err_cnt = 0;
      ifReq = 1'b1; ifAddr = 32'h500; mfc = 1'b0; memRdata = 32'hFFFFFFFF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (memEn) en_cnt++;
         if (err) err_cnt++;
         if (ifDone) begin
            done_cnt++; err_at = err; rd_at = rdata; ifReq = 1'b0;
         end
      end
      total++;
      if (en_cnt !== 15 || done_cnt !== 1) $display("FAIL timeout_len: wait=%0d dones=%0d expected 15 1", en_cnt, done_cnt);
      else passed++;
      total++;
      if (err_at !== 1'b1 || err_cnt !== 1) $display("FAIL timeout_err: err_at_done=%b err_cycles=%0d expected 1 1", err_at, err_cnt);
      else passed++;
      total++;
      if (rd_at !== 32'h0) $display("FAIL timeout_rdata: got %h expected 00000000", rd_at);
      else passed++;
      en_cnt = 0; done_cnt = 0; err_at = 1'b1;
      ifReq = 1'b1; memRdata = 32'h13572468;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (memEn) begin
            en_cnt++;
            if (en_cnt == 15) mfc = 1'b1;
         end
         if (ifDone) begin
            done_cnt++; err_at = err; rd_at = rdata; ifReq = 1'b0; mfc = 1'b0;
         end
      end
      total++;
      if (en_cnt !== 15 || done_cnt !== 1 || err_at !== 1'b0 || rd_at !== 32'h13572468)
         $display("FAIL timeout_mfc_priority: wait=%0d dones=%0d err=%b rdata=%h expected 15 1 0 13572468",
                  en_cnt, done_cnt, err_at, rd_at);
      else passed++;
`else
      int busy_cnt = 0;
      int err_cnt = 0;
      ifReq = 1'b1; ifAddr = 32'h500; mfc = 1'b0; memRdata = 32'h13572468;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (err) err_cnt++;
         if (ifDone) done_cnt++;
      end
      total++;
      if (busy_cnt !== 50 || done_cnt !== 0 || err_cnt !== 0)
         $display("FAIL no_timeout_hold: busy=%0d dones=%0d err=%0d expected 50 0 0", busy_cnt, done_cnt, err_cnt);
      else passed++;
      mfc = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (memEn) en_cnt++;
         if (ifDone) begin
            done_cnt++; err_at = err; rd_at = rdata; ifReq = 1'b0; mfc = 1'b0;
         end
      end
      total++;
      if (done_cnt !== 1 || err_at !== 1'b0 || rd_at !== 32'h13572468)
         $display("FAIL no_timeout_finish: dones=%0d err=%b rdata=%h expected 1 0 13572468", done_cnt, err_at, rd_at);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_mfc_ignored();
      test_arbitration();
      test_write();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
